// File: rtl/uart_rx_packet_ctrl.sv
// Frames the UART RX byte stream into length-prefixed, checksummed packets.
// The payload is buffered and released over valid/ready only after the checksum passes.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_Rx_Done,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Pkt_Valid,
    input  logic       i_Pkt_Ready,
    output logic [7:0] o_Pkt_Byte,
    output logic       o_Pkt_Last,
    output logic [7:0] o_Pkt_Len,
    output logic       o_Busy,
    output logic       o_Chk_Err,
    output logic       o_Len_Err,
    output logic       o_Timeout,
    output logic       o_Overrun
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [TW-1:0] TMO_ONE  = 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

    state_t        r_state;
    logic [7:0]    r_len;
    logic [7:0]    r_acc;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_buf [0:MAX_LEN-1];
    logic          r_pkt_valid;
    logic [7:0]    r_pkt_byte;
    logic          r_pkt_last;
    logic [7:0]    r_pkt_len;
    logic          r_chk_err;
    logic          r_len_err;
    logic          r_timeout;
    logic          r_overrun;

    logic [7:0]    w_acc_sum;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic          w_in_pkt;
    logic          w_xfer;

    assign w_acc_sum = r_acc + i_Rx_Byte;
    assign w_wr_nxt  = r_wr_ptr + PTR_ONE;
    assign w_rd_nxt  = r_rd_ptr + PTR_ONE;
    assign w_in_pkt  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign w_xfer    = r_pkt_valid & i_Pkt_Ready;

    // Write is gated by wr_ptr < LEN <= MAX_LEN, so the truncated index never aliases.
    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && i_Rx_Done)
            r_buf[r_wr_ptr[AW-1:0]] <= i_Rx_Byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_HUNT;
            r_len       <= 8'h00;
            r_acc       <= 8'h00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tmo       <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_byte  <= 8'h00;
            r_pkt_last  <= 1'b0;
            r_pkt_len   <= 8'h00;
            r_chk_err   <= 1'b0;
            r_len_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_chk_err <= 1'b0;
            r_len_err <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;

            // A strobe on the expiry cycle is handled below as a byte, so it wins.
            if (w_in_pkt && !i_Rx_Done) begin
                if (r_tmo == TMO_LAST) begin
                    r_timeout <= 1'b1;
                    r_state   <= S_HUNT;
                end else begin
                    r_tmo <= r_tmo + TMO_ONE;
                end
            end

            case (r_state)
                S_HUNT: begin
                    if (i_Rx_Done && i_Rx_Byte == SYNC_BYTE) begin
                        r_state <= S_LEN;
                        r_tmo   <= '0;
                    end
                end
                S_LEN: begin
                    if (i_Rx_Done) begin
                        r_tmo    <= '0;
                        r_len    <= i_Rx_Byte;
                        r_acc    <= i_Rx_Byte;
                        r_wr_ptr <= '0;
                        if (i_Rx_Byte == 8'h00 || i_Rx_Byte > LEN_MAX) begin
                            r_len_err <= 1'b1;
                            r_state   <= S_HUNT;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (i_Rx_Done) begin
                        r_tmo    <= '0;
                        r_acc    <= w_acc_sum;
                        r_wr_ptr <= w_wr_nxt;
                        if (8'(w_wr_nxt) == r_len)
                            r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (i_Rx_Done) begin
                        r_tmo <= '0;
                        if (w_acc_sum == 8'h00) begin
                            r_state     <= S_DRAIN;
                            r_rd_ptr    <= '0;
                            r_pkt_valid <= 1'b1;
                            r_pkt_byte  <= r_buf[0];
                            r_pkt_last  <= (r_len == 8'd1);
                            r_pkt_len   <= r_len;
                        end else begin
                            r_chk_err <= 1'b1;
                            r_state   <= S_HUNT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_Rx_Done)
                        r_overrun <= 1'b1;
                    if (w_xfer) begin
                        if (r_pkt_last) begin
                            r_state     <= S_HUNT;
                            r_pkt_valid <= 1'b0;
                            r_pkt_last  <= 1'b0;
                            r_pkt_byte  <= 8'h00;
                        end else begin
                            r_rd_ptr   <= w_rd_nxt;
                            r_pkt_byte <= r_buf[w_rd_nxt[AW-1:0]];
                            r_pkt_last <= (8'(w_rd_nxt) == r_len - 8'd1);
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign o_Pkt_Valid = r_pkt_valid;
    assign o_Pkt_Byte  = r_pkt_byte;
    assign o_Pkt_Last  = r_pkt_last;
    assign o_Pkt_Len   = r_pkt_len;
    assign o_Busy      = (r_state != S_HUNT);
    assign o_Chk_Err   = r_chk_err;
    assign o_Len_Err   = r_len_err;
    assign o_Timeout   = r_timeout;
    assign o_Overrun   = r_overrun;

endmodule

// File: doc/uart_rx_packet_ctrl.md
# uart_rx_packet_ctrl

Packet-level controller that sequences the UART receive datapath: it consumes the byte stream produced by the UART RX controller (one-cycle done strobe plus byte) and frames it into length-prefixed, checksummed command packets. Payload is buffered internally and released to the downstream command decoder over a valid/ready stream only after the checksum passes. Malformed, oversized or stalled packets are discarded with a one-cycle error pulse.

## Interface
- SYNC_BYTE, 8'hA5, start-of-packet marker.
- MAX_LEN, 16, maximum payload bytes (1..255); also the buffer depth.
- TIMEOUT_CYCLES, 1000, maximum clk cycles allowed between consecutive bytes inside a packet (>=2).
- clk  input  1  single system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_Rx_Done  input  1  one-cycle strobe; a received byte is valid on i_Rx_Byte.
- i_Rx_Byte  input  8  received byte; sampled only when i_Rx_Done=1.
- o_Pkt_Valid  output  1  payload byte available on o_Pkt_Byte.
- i_Pkt_Ready  input  1  downstream accepts the byte when o_Pkt_Valid & i_Pkt_Ready.
- o_Pkt_Byte  output  8  current payload byte.
- o_Pkt_Last  output  1  high with the final payload byte.
- o_Pkt_Len  output  8  length of the packet being drained; stable while o_Pkt_Valid=1.
- o_Busy  output  1  high in any state other than HUNT.
- o_Chk_Err  output  1  one-cycle pulse: checksum mismatch, packet dropped.
- o_Len_Err  output  1  one-cycle pulse: LEN=0 or LEN>MAX_LEN, packet dropped.
- o_Timeout  output  1  one-cycle pulse: inter-byte timeout, packet dropped.
- o_Overrun  output  1  one-cycle pulse: byte arrived during DRAIN and was discarded.

## Operation
- Frame: SYNC_BYTE, LEN, LEN payload bytes, CHK. Valid when (LEN + sum of payload + CHK) mod 256 = 0 (8-bit wrap-around accumulator).
- States: HUNT, LEN, PAYLOAD, CHECK, DRAIN.
- HUNT: bytes other than SYNC_BYTE ignored (no error); SYNC_BYTE -> LEN.
- LEN: byte loaded into length register and accumulator; 0 or >MAX_LEN -> o_Len_Err, HUNT; else -> PAYLOAD, write pointer 0.
- PAYLOAD: each byte written to buffer[wr_ptr], added to accumulator; after LEN-th byte -> CHECK.
- CHECK: CHK added; result 0 -> DRAIN, else o_Chk_Err, HUNT. A SYNC_BYTE value in LEN/PAYLOAD/CHECK is data, not a resync.
- DRAIN: read pointer from 0; advances on each valid&ready; o_Pkt_Last = (rd_ptr == LEN-1); after last transfer -> HUNT. Bytes arriving in DRAIN are dropped with o_Overrun (no resync until HUNT).
- Timeout counter: cleared on every i_Rx_Done and on entry to LEN; counts in LEN/PAYLOAD/CHECK; reaching TIMEOUT_CYCLES -> o_Timeout, HUNT. If i_Rx_Done and timeout coincide, the byte wins (counter clears, no error).
- Pointers/counters sized $clog2(MAX_LEN+1) / $clog2(TIMEOUT_CYCLES+1); no wrap inside a packet.

## Timing
- Reset: state HUNT; o_Pkt_Valid, o_Pkt_Last, o_Busy, all error pulses 0; o_Pkt_Byte 8'h00; o_Pkt_Len 8'h00; pointers, accumulator, timeout counter 0. Reset mid-packet or mid-drain discards everything immediately.
- Each i_Rx_Done is consumed on the edge where it is high; state update visible next cycle. Back-to-back strobes on consecutive cycles must be accepted.
- CHK strobe at edge N -> o_Pkt_Valid=1, o_Pkt_Byte=buffer[0] after edge N (visible cycle N+1).
- o_Pkt_Byte/o_Pkt_Last held stable while o_Pkt_Valid=1 and i_Pkt_Ready=0. Ready held high gives one byte per cycle; LEN bytes drain in LEN cycles.
- After the last transfer edge, o_Pkt_Valid=0 and o_Busy=0 the next cycle; a SYNC_BYTE strobe on that cycle is accepted.
- Error pulses: exactly one cycle, aligned with the HUNT-transition edge; buffer contents never presented.

## Test plan
- Good packet A5,03,11,22,33,CHK=97, ready tied high -> 3 valid cycles 11,22,33, last on 33, o_Pkt_Len=3, no error pulses.
- Same packet with CHK=98 -> o_Chk_Err single pulse, o_Pkt_Valid never asserted, o_Busy drops next cycle.
- Junk 00,FF then A5,00 -> junk ignored, o_Len_Err pulse on LEN; A5,11 (MAX_LEN=16) -> o_Len_Err.
- A5,02,AA then silence for TIMEOUT_CYCLES -> o_Timeout pulse, state HUNT; following valid packet received correctly.
- Good 4-byte packet with ready toggling 1,0,0,1,... plus an extra byte strobed during drain -> data held stable when stalled, all 4 bytes in order, o_Overrun one pulse.
- Assert reset_n=0 mid-PAYLOAD and mid-DRAIN -> all outputs at reset values asynchronously; next packet after release received correctly.
